// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage.
// Holds default widths, the $zero register index and the writeback-select encoding.
package mem_wb_stage_pkg;

  localparam int unsigned NB_DATA_DEF = 32;
  localparam int unsigned NB_REG_DEF  = 5;
  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned REG_ZERO    = 0;

  typedef enum logic [0:0] {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side entry and control inputs plus writeback/forwarding outputs.
// The slave modport belongs to the stage; the master modport belongs to the upstream driver.
interface mem_wb_stage_if #(
  parameter int CNT_W   = 32,
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
);
  logic               stall_in;
  logic               flush_in;
  logic               valid_in;
  logic [NB_DATA-1:0] read_data_in;
  logic [NB_DATA-1:0] alu_result_in;
  logic [NB_REG-1:0]  write_register_in;
  logic               reg_write_in;
  logic               mem_to_reg_in;
  logic               halt_in;
  logic [NB_DATA-1:0] wb_write_data_out;
  logic [NB_REG-1:0]  wb_write_register_out;
  logic               wb_reg_write_out;
  logic               fwd_valid_out;
  logic [CNT_W-1:0]   retired_count_out;
  logic               halt_out;

  modport slave (
    input  stall_in, flush_in, valid_in, read_data_in, alu_result_in,
           write_register_in, reg_write_in, mem_to_reg_in, halt_in,
    output wb_write_data_out, wb_write_register_out, wb_reg_write_out,
           fwd_valid_out, retired_count_out, halt_out
  );

  modport master (
    output stall_in, flush_in, valid_in, read_data_in, alu_result_in,
           write_register_in, reg_write_in, mem_to_reg_in, halt_in,
    input  wb_write_data_out, wb_write_register_out, wb_reg_write_out,
           fwd_valid_out, retired_count_out, halt_out
  );
endinterface

// File: rtl/mem_wb_stage_wb_mux.sv
// Writeback source select; new sources (e.g. link PC) extend the select encoding.
module mem_wb_stage_wb_mux
  import mem_wb_stage_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  wb_sel_e            i_sel,
  input  logic [NB_DATA-1:0] i_read_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_data
);

  always_comb begin
    o_data = i_alu_result;
    case (i_sel)
      WB_SEL_ALU: o_data = i_alu_result;
      WB_SEL_MEM: o_data = i_read_data;
      default:    o_data = i_alu_result;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with writeback select, sticky halt and saturating retire counter.
// Outputs are combinational from the pipeline registers, so a capture is visible right after its edge.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5
) (
  input  logic           clk,
  input  logic           reset,
  mem_wb_stage_if.slave  bus
);

  logic               r_valid;
  logic [NB_DATA-1:0] r_read_data;
  logic [NB_DATA-1:0] r_alu_result;
  logic [NB_REG-1:0]  r_write_register;
  logic               r_reg_write;
  logic               r_mem_to_reg;
  logic               r_halt;
  logic [CNT_W-1:0]   r_retired;
  logic               r_halt_sticky;

  logic               w_load;
  logic               w_retire;
  wb_sel_e            w_wb_sel;
  logic [NB_DATA-1:0] w_wb_data;

  // Flush outranks stall, so a held entry can still be replaced by a bubble.
  assign w_load   = ~bus.flush_in & ~bus.stall_in;
  assign w_retire = w_load & bus.valid_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid          <= 1'b0;
      r_read_data      <= '0;
      r_alu_result     <= '0;
      r_write_register <= '0;
      r_reg_write      <= 1'b0;
      r_mem_to_reg     <= 1'b0;
      r_halt           <= 1'b0;
    end else if (bus.flush_in) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_halt      <= 1'b0;
    end else if (w_load) begin
      r_valid          <= bus.valid_in;
      r_read_data      <= bus.read_data_in;
      r_alu_result     <= bus.alu_result_in;
      r_write_register <= bus.write_register_in;
      r_reg_write      <= bus.valid_in & bus.reg_write_in;
      r_mem_to_reg     <= bus.mem_to_reg_in;
      r_halt           <= bus.valid_in & bus.halt_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_retire && !(&r_retired)) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Halt latches once a valid HALT sits in the register and survives flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_halt_sticky <= 1'b0;
    end else if (r_valid && r_halt) begin
      r_halt_sticky <= 1'b1;
    end
  end

  assign w_wb_sel = r_mem_to_reg ? WB_SEL_MEM : WB_SEL_ALU;

  mem_wb_stage_wb_mux #(
    .NB_DATA (NB_DATA)
  ) u_wb_mux (
    .i_sel        (w_wb_sel),
    .i_read_data  (r_read_data),
    .i_alu_result (r_alu_result),
    .o_data       (w_wb_data)
  );

  assign bus.wb_write_data_out     = w_wb_data;
  assign bus.wb_write_register_out = r_write_register;
  assign bus.wb_reg_write_out      = r_valid & r_reg_write &
                                     (r_write_register != NB_REG'(REG_ZERO));
  assign bus.fwd_valid_out         = bus.wb_reg_write_out;
  assign bus.retired_count_out     = r_retired;
  assign bus.halt_out              = r_halt_sticky;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage (CNT_W=4) with a queue-based scoreboard.
// The driver pushes each vector after its capture edge; the monitor pops and checks on the next falling edge.
module tb_mem_wb_stage;

  typedef struct packed {
    logic        rst, stl, fl, v;
    logic [31:0] rd, alu;
    logic [4:0]  wr;
    logic        rw, m2r, h, dc;
    logic [31:0] e_data;
    logic [4:0]  e_reg;
    logic        e_we;
    logic [3:0]  e_cnt;
    logic        e_halt;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  vec_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  mem_wb_stage_if #(.CNT_W(4), .NB_DATA(32), .NB_REG(5)) bus ();

  mem_wb_stage #(.CNT_W(4), .NB_DATA(32), .NB_REG(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, stl, fl, v, input logic [31:0] rd, alu,
                              input logic [4:0] wr, input logic rw, m2r, h, dc,
                              input logic [31:0] e_data, input logic [4:0] e_reg,
                              input logic e_we, input logic [3:0] e_cnt, input logic e_halt);
    vec_t t;
    t.rst = rst; t.stl = stl; t.fl = fl; t.v = v; t.rd = rd; t.alu = alu; t.wr = wr;
    t.rw = rw; t.m2r = m2r; t.h = h; t.dc = dc; t.e_data = e_data; t.e_reg = e_reg;
    t.e_we = e_we; t.e_cnt = e_cnt; t.e_halt = e_halt;
    return t;
  endfunction

  task automatic apply(input vec_t t);
    @(negedge clk);
    reset                 = t.rst;
    bus.stall_in          = t.stl;
    bus.flush_in          = t.fl;
    bus.valid_in          = t.v;
    bus.read_data_in      = t.rd;
    bus.alu_result_in     = t.alu;
    bus.write_register_in = t.wr;
    bus.reg_write_in      = t.rw;
    bus.mem_to_reg_in     = t.m2r;
    bus.halt_in           = t.h;
    @(posedge clk);
    exp_q.push_back(t);
  endtask

  // Scoreboard monitor: one vector check per falling edge with a pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      logic bad;
      e   = exp_q.pop_front();
      bad = 1'b0;
      n_vec++;
      if (!e.dc && bus.wb_write_data_out !== e.e_data) begin
        $display("FAIL vec%0d wb_data got %h want %h", n_vec, bus.wb_write_data_out, e.e_data);
        bad = 1'b1;
      end
      if (!e.dc && bus.wb_write_register_out !== e.e_reg) begin
        $display("FAIL vec%0d wb_reg got %0d want %0d", n_vec, bus.wb_write_register_out, e.e_reg);
        bad = 1'b1;
      end
      if (bus.wb_reg_write_out !== e.e_we) begin
        $display("FAIL vec%0d wb_we got %b want %b", n_vec, bus.wb_reg_write_out, e.e_we);
        bad = 1'b1;
      end
      if (bus.fwd_valid_out !== e.e_we) begin
        $display("FAIL vec%0d fwd_valid got %b want %b", n_vec, bus.fwd_valid_out, e.e_we);
        bad = 1'b1;
      end
      if (bus.retired_count_out !== e.e_cnt) begin
        $display("FAIL vec%0d retired got %0d want %0d", n_vec, bus.retired_count_out, e.e_cnt);
        bad = 1'b1;
      end
      if (bus.halt_out !== e.e_halt) begin
        $display("FAIL vec%0d halt got %b want %b", n_vec, bus.halt_out, e.e_halt);
        bad = 1'b1;
      end
      if (bad) n_miss++;
    end
  end

  initial begin
    reset = 1'b1;
    bus.stall_in = 1'b0; bus.flush_in = 1'b0; bus.valid_in = 1'b0;
    bus.read_data_in = 32'h0; bus.alu_result_in = 32'h0; bus.write_register_in = 5'd0;
    bus.reg_write_in = 1'b0; bus.mem_to_reg_in = 1'b0; bus.halt_in = 1'b0;

    //       rst   stl   fl    v     rd            alu           wr     rw    m2r   h     dc    e_data        e_reg  we    cnt   halt
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0,  1'b0, 4'd0, 1'b0));
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0,  1'b0, 4'd0, 1'b0));
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0,  1'b0, 4'd0, 1'b0));
    // ALU writeback, then load writeback, then load to $zero
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h11111111, 32'h0000002A, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0000002A, 5'd8,  1'b1, 4'd1, 1'b0));
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h00000005, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 5'd3,  1'b1, 4'd2, 1'b0));
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h00000005, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 5'd0,  1'b0, 4'd3, 1'b0));
    // load to r5, then three stalled cycles with changing inputs
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h00C0FFEE, 32'h00000007, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, 32'h00C0FFEE, 5'd5,  1'b1, 4'd4, 1'b0));
    apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'h00000009, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 32'h00C0FFEE, 5'd5,  1'b1, 4'd4, 1'b0));
    apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'hAAAA5555, 32'h0000000A, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00C0FFEE, 5'd5,  1'b1, 4'd4, 1'b0));
    apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000FFFF, 32'h0000000B, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00C0FFEE, 5'd5,  1'b1, 4'd4, 1'b0));
    // flush together with stall inserts a bubble
    apply(mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h87654321, 32'h0000000C, 5'd12, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        5'd0,  1'b0, 4'd4, 1'b0));
    // invalid entry: reg_write and halt inputs must be ignored
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h00000033, 5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 32'h00000033, 5'd7,  1'b0, 4'd4, 1'b0));
    // HALT: sticky flag appears one edge after capture, survives a flush
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        5'd0,  1'b0, 4'd5, 1'b0));
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        5'd0,  1'b0, 4'd5, 1'b1));
    apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h00000044, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        5'd0,  1'b0, 4'd5, 1'b1));
    // reset during a stall clears everything
    apply(mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        32'h00000055, 5'd6,  1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        5'd0,  1'b0, 4'd0, 1'b0));

    // 17 retirements: count saturates at 15
    for (int i = 0; i < 17; i++) begin
      logic [3:0] c;
      c = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h00000100 + 32'(i), 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0,
               32'h00000100 + 32'(i), 5'(i + 1), 1'b1, c, 1'b0));
    end
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h00000200, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00000200, 5'd20, 1'b1, 4'd15, 1'b0));

    @(negedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain pending got %0d want 0", exp_q.size());
      n_miss++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
